// File: rtl/eth_sw_out_arb_if.sv
// Handshake bundle between N ingress word streams, the output arbiter and the
// single egress word stream. The arbiter uses the slave modport.
interface eth_sw_out_arb_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int PORT_W  = $clog2(N_PORTS)
) ();
  logic [N_PORTS-1:0]        i_valid;
  logic [N_PORTS*DATA_W-1:0] i_data;
  logic [N_PORTS-1:0]        i_start;
  logic [N_PORTS-1:0]        i_end;
  logic [N_PORTS-1:0]        o_stall;
  logic                      i_ds_stall;
  logic                      o_valid;
  logic [DATA_W-1:0]         o_data;
  logic                      o_start;
  logic                      o_end;
  logic [PORT_W-1:0]         o_port;
  logic                      o_trunc;

  modport master (
    output i_valid, i_data, i_start, i_end, i_ds_stall,
    input  o_stall, o_valid, o_data, o_start, o_end, o_port, o_trunc
  );

  modport slave (
    input  i_valid, i_data, i_start, i_end, i_ds_stall,
    output o_stall, o_valid, o_data, o_start, o_end, o_port, o_trunc
  );
endinterface

// File: rtl/eth_sw_out_arb.sv
// Round-robin whole-frame arbiter: N ingress ports onto one egress stream,
// with downstream backpressure, source-port tag and max-length truncation.
module eth_sw_out_arb #(
  parameter int N_PORTS   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 64,
  parameter int PORT_W    = $clog2(N_PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  eth_sw_out_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t            state;
  logic [PORT_W-1:0] owner;
  logic [PORT_W-1:0] rr_last;
  logic [CNT_W-1:0]  count;

  logic [N_PORTS-1:0] req;
  logic               found;
  logic [PORT_W-1:0]  winner;
  logic [PORT_W-1:0]  gnt;
  logic               accept;
  logic               emit;
  logic               at_limit;
  logic               nxt_start;
  logic               nxt_end;
  logic               nxt_trunc;

  // Round-robin scan starting one past the last granted port, with wrap.
  always_comb begin
    int                idx;
    logic [PORT_W-1:0] cand;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    req    = bus.i_valid & bus.i_start;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx  = (int'(rr_last) + i) % N_PORTS;
      cand = PORT_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    gnt       = (state == IDLE) ? winner : owner;
    accept    = 1'b0;
    at_limit  = (count == CNT_W'(MAX_WORDS - 1));
    unique case (state)
      IDLE:    accept = found && !bus.i_ds_stall;
      XFER:    accept = bus.i_valid[gnt] && !bus.i_ds_stall;
      DRAIN:   accept = bus.i_valid[gnt];
      default: accept = 1'b0;
    endcase
    accept    = accept && !rst;
    emit      = accept && (state != DRAIN);
    nxt_start = (state == IDLE);
    nxt_trunc = (state == XFER) && !bus.i_end[gnt] && at_limit;
    nxt_end   = bus.i_end[gnt] || nxt_trunc;
    bus.o_stall = '1;
    if (accept) bus.o_stall[gnt] = 1'b0;
  end

  // NOTE: all state here is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      rr_last     <= PORT_W'(N_PORTS - 1);
      count       <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_start <= 1'b0;
      bus.o_end   <= 1'b0;
      bus.o_port  <= '0;
      bus.o_trunc <= 1'b0;
    end else begin
      // Egress register freezes entirely while downstream is stalled.
      if (!bus.i_ds_stall) begin
        bus.o_valid <= emit;
        bus.o_start <= emit && nxt_start;
        bus.o_end   <= emit && nxt_end;
        bus.o_trunc <= emit && nxt_trunc;
        if (emit) begin
          bus.o_data <= bus.i_data[int'(gnt)*DATA_W +: DATA_W];
          bus.o_port <= gnt;
        end
      end

      if (accept) begin
        unique case (state)
          IDLE: begin
            rr_last <= winner;
            count   <= CNT_W'(1);
            if (!bus.i_end[gnt]) begin
              owner <= winner;
              state <= XFER;
            end
          end
          XFER: begin
            count <= count + 1'b1;
            if (bus.i_end[gnt])  state <= IDLE;
            else if (at_limit)   state <= DRAIN;
          end
          DRAIN: begin
            // Tail of a truncated frame is swallowed until its end word.
            if (bus.i_end[gnt]) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_sw_out_arb.sv
// Directed bench for eth_sw_out_arb: queued per-port sources that honour stall,
// an egress capture queue, and hand-computed expected frames.
module tb_eth_sw_out_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int PW = 2;

  typedef struct packed {
    logic          trunc;
    logic [PW-1:0] port;
    logic          s;
    logic          e;
    logic [DW-1:0] d;
  } eg_t;

  logic clk = 1'b0;
  logic rst;

  eth_sw_out_arb_if #(.N_PORTS(N), .DATA_W(DW), .PORT_W(PW)) bus ();

  eth_sw_out_arb #(.N_PORTS(N), .DATA_W(DW), .MAX_WORDS(MW), .PORT_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW+1:0] src_q [N][$];  // {start, end, data}
  eg_t           eg_q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [DW+1:0] w;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        w = src_q[k][0];
        bus.i_valid[k]          = 1'b1;
        bus.i_start[k]          = w[DW+1];
        bus.i_end[k]            = w[DW];
        bus.i_data[k*DW +: DW]  = w[DW-1:0];
      end else begin
        bus.i_valid[k]          = 1'b0;
        bus.i_start[k]          = 1'b0;
        bus.i_end[k]            = 1'b0;
        bus.i_data[k*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic push_frame(input int port, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      src_q[port].push_back({(i == 0), (i == n - 1), base + DW'(i)});
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += src_q[k].size();
    return s;
  endfunction

  // One clock: sample handshakes before the edge, pop accepted words after it.
  task automatic step();
    logic [N-1:0] acc;
    #2;
    acc = bus.i_valid & ~bus.o_stall;
    if (bus.o_valid && !bus.i_ds_stall)
      eg_q.push_back({bus.o_trunc, bus.o_port, bus.o_start, bus.o_end, bus.o_data});
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (acc[k]) void'(src_q[k].pop_front());
    drive();
  endtask

  task automatic flush(input string tag, input int budget);
    int pend;
    int n = 0;
    pend = pending();
    while (pend > 0 && n < budget) begin
      step();
      n++;
      pend = pending();
    end
    repeat (3) step();
    check({tag, "_drained"}, pend, 0);
  endtask

  task automatic expect_frame(input string tag, input int port, input logic [DW-1:0] base,
                              input int n, input bit trunc);
    eg_t got;
    eg_t exp;
    check({tag, "_len"}, (eg_q.size() >= n), 1);
    for (int i = 0; i < n && eg_q.size() > 0; i++) begin
      got       = eg_q.pop_front();
      exp.trunc = trunc && (i == n - 1);
      exp.port  = PW'(port);
      exp.s     = (i == 0);
      exp.e     = (i == n - 1);
      exp.d     = base + DW'(i);
      check($sformatf("%s_w%0d", tag, i), got, exp);
    end
  endtask

  initial begin
    eg_t got;
    rst = 1'b1;
    bus.i_ds_stall = 1'b0;
    drive();
    @(posedge clk);
    #1;
    check("rst_valid", bus.o_valid, 0);
    check("rst_data",  bus.o_data,  0);
    check("rst_start", bus.o_start, 0);
    check("rst_end",   bus.o_end,   0);
    check("rst_port",  bus.o_port,  0);
    check("rst_trunc", bus.o_trunc, 0);
    check("rst_stall", bus.o_stall, 4'b1111);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();

    // Three-way contention from reset priority: 0, 1, 3.
    push_frame(0, 32'h100, 2);
    push_frame(1, 32'h110, 2);
    push_frame(3, 32'h130, 2);
    drive();
    #1;
    check("cont_first_stall", bus.o_stall, 4'b1110);
    flush("cont", 40);
    expect_frame("cont_p0", 0, 32'h100, 2, 1'b0);
    expect_frame("cont_p1", 1, 32'h110, 2, 1'b0);
    expect_frame("cont_p3", 3, 32'h130, 2, 1'b0);

    // Uncontended 4-word frame on port 2; last word sits exactly at the limit.
    push_frame(2, 32'hA0, 4);
    drive();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("single_stall_w%0d", i), bus.o_stall[2], 0);
      step();
      if (i == 0) begin
        check("single_lat_valid", bus.o_valid, 1);
        check("single_lat_data",  bus.o_data,  32'hA0);
        check("single_lat_start", bus.o_start, 1);
        check("single_lat_port",  bus.o_port,  2);
      end
    end
    flush("single", 10);
    expect_frame("single", 2, 32'hA0, 4, 1'b0);

    // Seed rr_last=1 with a one-word frame, then contention gives 3, 0, 1.
    push_frame(1, 32'h1F0, 1);
    drive();
    flush("seed", 10);
    expect_frame("seed", 1, 32'h1F0, 1, 1'b0);
    push_frame(0, 32'h200, 2);
    push_frame(1, 32'h210, 2);
    push_frame(3, 32'h230, 2);
    drive();
    #1;
    check("rr_first_stall", bus.o_stall, 4'b0111);
    flush("rr", 40);
    expect_frame("rr_p3", 3, 32'h230, 2, 1'b0);
    expect_frame("rr_p0", 0, 32'h200, 2, 1'b0);
    expect_frame("rr_p1", 1, 32'h210, 2, 1'b0);

    // Downstream backpressure for 3 cycles mid-frame.
    push_frame(2, 32'hB0, 4);
    drive();
    step();
    step();
    bus.i_ds_stall = 1'b1;
    repeat (3) begin
      #1;
      check("bp_owner_stall", bus.o_stall[2], 1);
      check("bp_hold_valid",  bus.o_valid,    1);
      check("bp_hold_data",   bus.o_data,     32'hB1);
      step();
    end
    bus.i_ds_stall = 1'b0;
    flush("bp", 20);
    expect_frame("bp", 2, 32'hB0, 4, 1'b0);

    // 7-word frame truncated at 4; tail drained even under backpressure.
    push_frame(1, 32'hF0, 7);
    drive();
    repeat (4) step();
    push_frame(2, 32'hC0, 2);
    drive();
    bus.i_ds_stall = 1'b1;
    #1;
    check("trunc_drain_stall", bus.o_stall, 4'b1101);
    check("trunc_out_trunc",   bus.o_trunc, 1);
    check("trunc_out_end",     bus.o_end,   1);
    check("trunc_out_data",    bus.o_data,  32'hF3);
    repeat (3) step();
    check("trunc_tail_taken", src_q[1].size(), 0);
    bus.i_ds_stall = 1'b0;
    flush("trunc", 20);
    expect_frame("trunc",      1, 32'hF0, 4, 1'b1);
    expect_frame("trunc_next", 2, 32'hC0, 2, 1'b0);

    // Single-word frame on port 0 followed immediately by port 1.
    push_frame(0, 32'hD0, 1);
    push_frame(1, 32'hE0, 2);
    drive();
    step();
    check("sw_valid", bus.o_valid, 1);
    check("sw_start", bus.o_start, 1);
    check("sw_end",   bus.o_end,   1);
    check("sw_data",  bus.o_data,  32'hD0);
    check("sw_port",  bus.o_port,  0);
    step();
    check("sw_next_valid", bus.o_valid, 1);
    check("sw_next_data",  bus.o_data,  32'hE0);
    check("sw_next_start", bus.o_start, 1);
    check("sw_next_port",  bus.o_port,  1);
    flush("sw", 10);
    expect_frame("sw0", 0, 32'hD0, 1, 1'b0);
    expect_frame("sw1", 1, 32'hE0, 2, 1'b0);

    // Reset during word 2 of a port-3 frame.
    push_frame(3, 32'h300, 4);
    drive();
    step();
    step();
    rst = 1'b1;
    #1;
    check("rstm_stall_pre", bus.o_stall, 4'b1111);
    step();
    check("rstm_valid", bus.o_valid, 0);
    check("rstm_data",  bus.o_data,  0);
    check("rstm_start", bus.o_start, 0);
    check("rstm_end",   bus.o_end,   0);
    check("rstm_port",  bus.o_port,  0);
    check("rstm_trunc", bus.o_trunc, 0);
    check("rstm_stall", bus.o_stall, 4'b1111);
    rst = 1'b0;
    push_frame(0, 32'h400, 2);
    drive();
    #1;
    check("rstm_grant_p0", bus.o_stall, 4'b1110);
    step();
    step();
    check("rstm_orphan_stalled", src_q[3].size(), 2);
    src_q[3].delete();
    drive();
    flush("rstm", 10);
    check("rstm_pre_len", (eg_q.size() >= 2), 1);
    if (eg_q.size() >= 2) begin
      got = eg_q.pop_front();
      check("rstm_pre_w0_data", got.d, 32'h300);
      check("rstm_pre_w0_end",  got.e, 0);
      got = eg_q.pop_front();
      check("rstm_pre_w1_data", got.d, 32'h301);
      check("rstm_pre_w1_end",  got.e, 0);
    end
    expect_frame("rstm_next", 0, 32'h400, 2, 1'b0);
    check("final_egress_empty", eg_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
